dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the pipelined MIPS core's MEM stage.
//   Accepts the word load/store requests the datapath issues (address, write data, write enable)
//   and returns read data after a fixed, parameterised wait-state latency.
//   Holds the pipeline with a stall line until each access completes.
//   Sits between the datapath MEM stage and the hazard/stall logic.
// PARAMETERS
//   DEPTH    64  number of 32-bit words in the array; power of two, >= 2
//   LATENCY  2   wait states per access; legal range 1..15
//   ADDR_W   6   word-index width, = log2(DEPTH)
// PORTS
//   clk        in   1   single clock; all state updates on the rising edge
//   reset      in   1   asynchronous, active-low reset
//   req        in   1   access request this cycle (load or store); datapath asserts it
//   we         in   1   1 = store, 0 = load; qualified by req
//   addr       in   32  byte address (aluout_mem); word index = addr[ADDR_W+1:2]
//   wdata      in   32  store data (writedata_mem)
//   rdata      out  32  load data (readdata_mem), registered
//   stall      out  1   1 = hold the pipeline; the current access is not finished
//   misalign   out  1   only with DMEM_MISALIGN_TRAP_EN: addr[1:0]!=0 on an accepted req
// BEHAVIOUR
//   Reset (reset=0, async):
//   - FSM returns to IDLE; wait counter = 0; rdata = 0; misalign = 0.
//   - Array contents are not reset.
//   FSM states:
//   - IDLE: if req, accept it: capture we/addr/wdata, load the counter with LATENCY-1, go to BUSY.
//     If LATENCY=1, go directly to DONE.
//   - BUSY: decrement the counter each cycle; when counter==0, go to DONE on the next edge.
//   - DONE: lasts exactly 1 cycle; return to IDLE.
//   stall:
//   - stall = (IDLE & req) | BUSY, combinational.
//   - In DONE, stall = 0, so the pipeline advances on that edge.
//   Timing: an access accepted in cycle 0 has stall high for cycles 0..LATENCY-1 and reaches DONE in cycle LATENCY.
//   Back-to-back: the request presented after DONE is accepted in the following IDLE cycle.
//   Commit point: stores and loads commit on the edge into DONE.
//   - Store: writes the captured wdata to the captured index.
//   - Load: loads rdata from the captured index.
//   rdata:
//   - Valid in DONE.
//   - Holds its value until the next load commits. Stores do not change rdata.
//   Capture: inputs are captured only at acceptance. Changes or deassertion of req while BUSY are ignored, and the access still completes.
//   Addressing:
//   - Addresses beyond DEPTH wrap modulo DEPTH; upper address bits are ignored.
//   - Without the trap feature, addr[1:0] is ignored.
//   Reset mid-access: the access is aborted. A store that has not yet reached its DONE edge is not written.
//   Load after store to the same word: the load returns the stored value, because the store committed in an earlier DONE cycle.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined:
//   - An accepted req with addr[1:0]!=0 sets misalign in DONE, held 1 cycle.
//   - A misaligned store is suppressed (no array write).
//   - A misaligned load returns 32'h0.
//   - Latency and stall timing are unchanged.
//   DMEM_MISALIGN_TRAP_EN undefined:
//   - No misalign port.
//   - addr[1:0] is ignored; every access is treated as aligned.
// STRUCTURE
//   Shared include dmem_defs.vh:
//   - FSM state encodings S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2.
//   - Counter width constant DMEM_CNT_W=4.
//   One sub-module, ram_sp: single-port synchronous RAM (DEPTH x 32) with write enable.
//   - Write on clk; registered read.
//   - Instantiated once; the FSM drives its enable at the commit edge.
// TESTING
//   1. Release reset -> rdata=0, stall=0, state IDLE. With req=0 for 10 cycles, stall stays 0.
//   2. LATENCY=2: store 32'hDEADBEEF @0x10, then load @0x10 -> stall=1 for 2 cycles per access; rdata=DEADBEEF in the load's DONE cycle.
//   3. Back-to-back loads @0x0/0x4 preloaded 11111111/22222222 -> two DONE cycles 3 cycles apart; rdata is 11111111 then 22222222.
//   4. Wrap: store 32'hA5A5A5A5 @0x100 with DEPTH=64 -> a load @0x0 returns A5A5A5A5.
//   5. Reset asserted in BUSY of a store of 32'h12345678 @0x8 -> after release, a load @0x8 returns the old preloaded value.
//   6. With DMEM_MISALIGN_TRAP_EN: store @0x6 -> misalign=1 in DONE and the array is unchanged. A load @0x6 returns 0 with misalign=1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the dmem_responder data-memory slice.
// FSM encodings and wait-counter width are fixed here so every file agrees.
package dmem_responder_pkg;

    localparam int DMEM_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } dmem_state_e;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return (byte_addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the datapath and dmem_responder.
// The misalign line exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
`ifdef DMEM_MISALIGN_TRAP_EN
        input  misalign,
`endif
        input  rdata,
        input  stall
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
`ifdef DMEM_MISALIGN_TRAP_EN
        output misalign,
`endif
        output rdata,
        output stall
    );

endinterface

// File: rtl/dmem_responder_ram_sp.sv
// Single-port synchronous RAM, DEPTH x 32: en&we writes, en&!we loads the read register.
// rd_zero forces the read register to zero instead of the array word.
module ram_sp #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH];

    // Array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: only loads update it, so stores leave the last load visible
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'h0000_0000;
        end else if (en && !we) begin
            rdata <= rd_zero ? 32'h0000_0000 : mem_r[addr];
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MIPS MEM stage; stalls the pipe per access.
// Optional misalignment trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [DMEM_CNT_W-1:0] LAT_M1  = DMEM_CNT_W'(LATENCY - 1);
    localparam logic [DMEM_CNT_W-1:0] CNT_ONE = 4'd1;

    dmem_state_e             state_r;
    logic [DMEM_CNT_W-1:0]   cnt_r;
    logic                    we_r;
    logic [ADDR_W-1:0]       idx_r;
    logic [31:0]             wdata_r;

    logic                    accept_s;
    logic                    commit_s;
    logic                    stall_s;
    logic                    cur_we_s;
    logic [ADDR_W-1:0]       cur_idx_s;
    logic [31:0]             cur_wdata_s;
    logic                    cur_mis_s;
    logic                    ram_en_s;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic                    mis_r;
    logic                    misalign_r;
`endif

    // Accept/commit decode; commit is the edge that moves the FSM into DONE
    always_comb begin
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                accept_s = bus.req;
                if (LATENCY == 1) begin
                    commit_s = bus.req;
                end else begin
                    commit_s = 1'b0;
                end
            end
            S_BUSY: begin
                commit_s = (cnt_r == CNT_ONE);
            end
            S_DONE: begin
                commit_s = 1'b0;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Operand select: live bus when accepting and committing in one edge, captured copy otherwise
    always_comb begin
        cur_we_s    = we_r;
        cur_idx_s   = idx_r;
        cur_wdata_s = wdata_r;
        if (state_r == S_IDLE) begin
            cur_we_s    = bus.we;
            cur_idx_s   = bus.addr[ADDR_W+1:2];
            cur_wdata_s = bus.wdata;
        end else begin
            cur_we_s    = we_r;
            cur_idx_s   = idx_r;
            cur_wdata_s = wdata_r;
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        if (state_r == S_IDLE) begin
            cur_mis_s = is_misaligned(bus.addr);
        end else begin
            cur_mis_s = mis_r;
        end
`else
        cur_mis_s = 1'b0;
`endif
    end

    // A misaligned store is dropped entirely; a misaligned load still reads (as zero)
    assign ram_en_s  = commit_s && !(cur_we_s && cur_mis_s);
    assign stall_s   = accept_s || (state_r == S_BUSY);
    assign bus.stall = stall_s;

    // Access FSM with request capture and wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            idx_r   <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.req) begin
                        we_r    <= bus.we;
                        idx_r   <= bus.addr[ADDR_W+1:2];
                        wdata_r <= bus.wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                        mis_r   <= is_misaligned(bus.addr);
`endif
                        cnt_r   <= LAT_M1;
                        state_r <= (LATENCY == 1) ? S_DONE : S_BUSY;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // Counter reaches zero on the same edge the FSM enters DONE
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_BUSY;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misalign flag: high for exactly the DONE cycle of a trapped access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= commit_s && cur_mis_s;
        end
    end

    assign bus.misalign = misalign_r;
`endif

    ram_sp #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .en      (ram_en_s),
        .we      (cur_we_s),
        .rd_zero (cur_mis_s),
        .addr    (cur_idx_s),
        .wdata   (cur_wdata_s),
        .rdata   (bus.rdata)
    );

endmodule
